debug_slave_cmd_engine: RTL
===========================

DEBUG_SLAVE_CMD_ENGINE -- requirements
Module: debug_slave_cmd_engine

Interface
REQ-001 Parameter IR_WIDTH, default 2: width of the JTAG instruction captured with each command.
REQ-002 Parameter DR_WIDTH, default 38: width of the JTAG shift register and of jdo.
REQ-003 Parameter ACTION_BIT, default 34: index of the sr bit that selects action (1) or no-action (0).
REQ-004 Parameter SYNC_STAGES, default 2, legal range 2..4: synchroniser depth.
REQ-005 Parameter FIFO_DEPTH, default 4, legal values power of two >= 2: command queue depth.
REQ-006 One clock, clk; reset is asynchronous and active-high, named reset.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 vs_udr  in  1  JTAG update-DR level, asynchronous to clk.
REQ-010 vs_uir  in  1  JTAG update-IR level, asynchronous to clk.
REQ-011 ir_in  in  IR_WIDTH  current JTAG instruction, stable while vs_udr is high.
REQ-012 sr  in  DR_WIDTH  JTAG shift register, stable while vs_udr is high.
REQ-013 cmd_ready  in  1  consumer accepts the head command.
REQ-014 clr_overflow  in  1  clears the overflow flag.
REQ-015 jdo  out  DR_WIDTH  last captured sr.
REQ-016 cmd_valid  out  1  head command present.
REQ-017 cmd_ir  out  IR_WIDTH  head command instruction.
REQ-018 cmd_data  out  DR_WIDTH  head command data.
REQ-019 cmd_action  out  1  head command action flag.
REQ-020 fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entry count.
REQ-021 overflow  out  1  sticky lost-command flag.
REQ-022 uir_pulse  out  1  one-cycle pulse per update-IR.

Function
REQ-023 vs_udr and vs_uir each pass through a SYNC_STAGES flop chain; a rising edge is detected one cycle after the synchronised level rises (udr_edge, uir_edge).
REQ-024 Edge detection uses a two-state arm FSM per input: DISARMED (after reset) -> ARMED when the synchronised level is observed low; edges are reported only in ARMED.
REQ-025 On udr_edge: jdo <= sr and entry {ir_in, sr, sr[ACTION_BIT]} is pushed, both registered on that clk edge.
REQ-026 Latency: cmd_valid rises in the cycle after udr_edge when the queue was empty.
REQ-027 Pop occurs on a clk edge where cmd_valid && cmd_ready; cmd_* hold stable while cmd_valid && !cmd_ready.
REQ-028 Push when full without simultaneous pop: entry is dropped, jdo still updates, overflow sets.
REQ-029 Push when full with simultaneous pop: both complete, level unchanged, no overflow.
REQ-030 Push and pop on an empty queue: push completes, pop ignored (cmd_valid was low).
REQ-031 Read/write pointers wrap modulo FIFO_DEPTH; fifo_level counts 0..FIFO_DEPTH.
REQ-032 overflow clears on clr_overflow; simultaneous set and clear leaves overflow = 1.
REQ-033 uir_edge drives uir_pulse high for exactly one cycle; the queue is unaffected.
REQ-034 cmd_ir, cmd_data and cmd_action are 0 when the queue is empty.

Reset
REQ-035 reset clears synchroniser chains, arm FSMs (DISARMED), pointers, fifo_level, jdo, overflow, uir_pulse and cmd_valid to 0, independent of clk.
REQ-036 Reset mid-operation discards all queued entries; an update-DR level still high at deassertion produces no command.

Structure
REQ-037 Package debug_slave_pkg holds the parameter defaults and the queue-entry struct (ir, data, action).
REQ-038 The synchroniser and arm FSM form one sub-module, debug_slave_sync_edge, instantiated twice.

Verification
REQ-039 Single update: vs_udr rises with sr=38'h04_0000_1234, ir_in=2'b00; after SYNC_STAGES+2 clk cmd_valid=1, cmd_data=38'h04_0000_1234, cmd_action=1, jdo matches.
REQ-040 Backpressure: cmd_ready=0 with 5 updates at FIFO_DEPTH=4 -> fifo_level=4, overflow=1, jdo = fifth sr, head = first sr.
REQ-041 Full with simultaneous push/pop: level stays 4, overflow stays 0, order preserved over 8 pops.
REQ-042 Reset with vs_udr held high, then release: cmd_valid stays 0 until vs_udr goes low and high again.
REQ-043 clr_overflow asserted in the same cycle as a dropped push: overflow remains 1; asserted alone next cycle: overflow = 0.
REQ-044 vs_uir toggled 3 times: exactly 3 single-cycle uir_pulse assertions, fifo_level unchanged.

Source files
------------

// File: rtl/debug_slave_pkg.sv
// Shared defaults and types for the debug-slave command engine.
// The queue-entry struct here is sized for the default configuration.
package debug_slave_pkg;

    localparam int DEFAULT_IR_WIDTH    = 2;
    localparam int DEFAULT_DR_WIDTH    = 38;
    localparam int DEFAULT_ACTION_BIT  = 34;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

    typedef enum logic {
        ARM_DISARMED = 1'b0,
        ARM_ARMED    = 1'b1
    } arm_state_t;

    typedef struct packed {
        logic [DEFAULT_IR_WIDTH-1:0] ir;
        logic [DEFAULT_DR_WIDTH-1:0] data;
        logic                        action;
    } cmd_entry_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/debug_slave_sync_edge.sv
// Synchronises one asynchronous JTAG level into clk and reports its rising
// edges as a single-cycle registered pulse, but only once the line was seen low.
module debug_slave_sync_edge
    import debug_slave_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic edge_o
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    arm_state_t             state_q, state_d;
    logic                   prev_q;
    logic                   edge_q, edge_d;
    logic                   level;
    logic                   level_valid;

    assign sync_d[0] = async_i;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign level = sync_q[SYNC_STAGES-1];
    // The zeros flushed in by reset are not a real observation of the line;
    // arming waits until the whole chain holds sampled input.
    assign level_valid = (fill_q == FILL_W'(SYNC_STAGES));

    always_comb begin
        state_d = state_q;
        edge_d  = 1'b0;
        fill_d  = level_valid ? fill_q : fill_q + FILL_W'(1);
        case (state_q)
            ARM_DISARMED: begin
                if (level_valid && !level) begin
                    state_d = ARM_ARMED;
                end
            end
            ARM_ARMED: begin
                edge_d = level && !prev_q;
            end
            default: begin
                state_d = ARM_DISARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            fill_q  <= '0;
            state_q <= ARM_DISARMED;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            prev_q  <= level;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/debug_slave_cmd_engine.sv
// Captures JTAG update-DR commands into a small FIFO for the clk-domain
// consumer, mirrors the last shift register on jdo and pulses on update-IR.
module debug_slave_cmd_engine
    import debug_slave_pkg::*;
#(
    parameter int IR_WIDTH    = DEFAULT_IR_WIDTH,
    parameter int DR_WIDTH    = DEFAULT_DR_WIDTH,
    parameter int ACTION_BIT  = DEFAULT_ACTION_BIT,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    input  logic [IR_WIDTH-1:0]             ir_in,
    input  logic [DR_WIDTH-1:0]             sr,
    input  logic                            cmd_ready,
    input  logic                            clr_overflow,
    output logic [DR_WIDTH-1:0]             jdo,
    output logic                            cmd_valid,
    output logic [IR_WIDTH-1:0]             cmd_ir,
    output logic [DR_WIDTH-1:0]             cmd_data,
    output logic                            cmd_action,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            uir_pulse
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = level_width(FIFO_DEPTH);

    // Same layout as cmd_entry_t, widened to this instance's parameters.
    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [DR_WIDTH-1:0] data;
        logic                action;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             head;
    entry_t             wr_entry;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [DR_WIDTH-1:0] jdo_q, jdo_d;
    logic               overflow_q, overflow_d;
    logic               uir_pulse_q;
    logic               udr_edge, uir_edge;
    logic               empty, full, push, pop, drop;

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (vs_udr),
        .edge_o  (udr_edge)
    );

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (vs_uir),
        .edge_o  (uir_edge)
    );

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = !empty && cmd_ready;
        // A pop in the same cycle frees the slot the push needs.
        push     = udr_edge && (!full || pop);
        drop     = udr_edge && full && !pop;
        wr_entry = '{ir: ir_in, data: sr, action: sr[ACTION_BIT]};

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        jdo_d = udr_edge ? sr : jdo_q;

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            jdo_q       <= '0;
            overflow_q  <= 1'b0;
            uir_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            jdo_q       <= jdo_d;
            overflow_q  <= overflow_d;
            uir_pulse_q <= uir_edge;
        end
    end

    // Storage carries no reset: pointers and level alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign head       = mem[rd_ptr_q];
    assign cmd_valid  = !empty;
    assign cmd_ir     = empty ? '0 : head.ir;
    assign cmd_data   = empty ? '0 : head.data;
    assign cmd_action = empty ? 1'b0 : head.action;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign jdo        = jdo_q;
    assign uir_pulse  = uir_pulse_q;

endmodule
